// File: rtl/gps_pkg.sv
// Shared constants for the tracking-channel readout: register addresses,
// status bit positions and the measurement bank payload.
package gps_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CARR_W  = 32;
    localparam int unsigned CODE_W  = 21;
    localparam int unsigned EPOCH_W = 11;
    localparam int unsigned FLAG_W  = 4;

    localparam int unsigned ADDR_IE     = 0;
    localparam int unsigned ADDR_QE     = 1;
    localparam int unsigned ADDR_IP     = 2;
    localparam int unsigned ADDR_QP     = 3;
    localparam int unsigned ADDR_IL     = 4;
    localparam int unsigned ADDR_QL     = 5;
    localparam int unsigned ADDR_CARR   = 6;
    localparam int unsigned ADDR_CODE   = 7;
    localparam int unsigned ADDR_EPOCH  = 8;
    localparam int unsigned ADDR_EPCHK  = 9;
    localparam int unsigned ADDR_STATUS = 10;

    localparam int unsigned ST_ACCUM_NEW    = 0;
    localparam int unsigned ST_ACCUM_MISSED = 1;
    localparam int unsigned ST_MEAS_NEW     = 2;
    localparam int unsigned ST_MEAS_MISSED  = 3;

    typedef struct packed {
        logic [CARR_W-1:0]  carrier;
        logic [CODE_W-1:0]  code;
        logic [EPOCH_W-1:0] epoch;
        logic [EPOCH_W-1:0] epoch_check;
    } meas_t;

endpackage

// File: rtl/capture_flag.sv
// New/missed flag pair: set by a capture, cleared by a status read.
// A capture coincident with the clear wins; missed uses the pre-clear value.
module capture_flag (
    input  logic clk,
    input  logic rstn,
    input  logic set,
    input  logic clr,
    output logic flag_new,
    output logic flag_missed
);

    logic new_nxt_c;
    logic missed_nxt_c;

    always_comb begin
        new_nxt_c    = flag_new;
        missed_nxt_c = flag_missed;
        if (clr) begin
            new_nxt_c    = 1'b0;
            missed_nxt_c = 1'b0;
        end
        if (set) begin
            new_nxt_c = 1'b1;
            if (flag_new) begin
                missed_nxt_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flag_new    <= 1'b0;
            flag_missed <= 1'b0;
        end else begin
            flag_new    <= new_nxt_c;
            flag_missed <= missed_nxt_c;
        end
    end

endmodule

// File: rtl/channel_readout.sv
// Per-channel capture banks for correlator dumps and tic measurements,
// read back through a one-cycle-latency addressed port.
module channel_readout
    import gps_pkg::*;
#(
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     dump,
    input  logic                     tic_enable,
    input  logic signed [ACC_W-1:0]  i_early,
    input  logic signed [ACC_W-1:0]  q_early,
    input  logic signed [ACC_W-1:0]  i_prompt,
    input  logic signed [ACC_W-1:0]  q_prompt,
    input  logic signed [ACC_W-1:0]  i_late,
    input  logic signed [ACC_W-1:0]  q_late,
    input  logic [CARR_W-1:0]        carrier_val,
    input  logic [CODE_W-1:0]        code_val,
    input  logic [EPOCH_W-1:0]       epoch,
    input  logic [EPOCH_W-1:0]       epoch_check,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     accum_int
);

    logic signed [ACC_W-1:0] ie_q, qe_q, ip_q, qp_q, il_q, ql_q;
    meas_t                   meas_q;

    logic                    accum_new, accum_missed;
    logic                    meas_new, meas_missed;
    logic                    status_rd_c;
    logic [FLAG_W-1:0]       status_c;
    logic [DATA_W-1:0]       rd_mux_c;

    assign status_rd_c = rd_en && (rd_addr == ADDR_W'(ADDR_STATUS));

    capture_flag u_accum_flag (
        .clk         (clk),
        .rstn        (rstn),
        .set         (dump),
        .clr         (status_rd_c),
        .flag_new    (accum_new),
        .flag_missed (accum_missed)
    );

    capture_flag u_meas_flag (
        .clk         (clk),
        .rstn        (rstn),
        .set         (tic_enable),
        .clr         (status_rd_c),
        .flag_new    (meas_new),
        .flag_missed (meas_missed)
    );

    // Accumulation bank: latest dump always overwrites.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ie_q <= '0;
            qe_q <= '0;
            ip_q <= '0;
            qp_q <= '0;
            il_q <= '0;
            ql_q <= '0;
        end else if (dump) begin
            ie_q <= i_early;
            qe_q <= q_early;
            ip_q <= i_prompt;
            qp_q <= q_prompt;
            il_q <= i_late;
            ql_q <= q_late;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meas_q <= '0;
        end else if (tic_enable) begin
            meas_q.carrier     <= carrier_val;
            meas_q.code        <= code_val;
            meas_q.epoch       <= epoch;
            meas_q.epoch_check <= epoch_check;
        end
    end

    always_comb begin
        status_c                  = '0;
        status_c[ST_ACCUM_NEW]    = accum_new;
        status_c[ST_ACCUM_MISSED] = accum_missed;
        status_c[ST_MEAS_NEW]     = meas_new;
        status_c[ST_MEAS_MISSED]  = meas_missed;
    end

    // Read mux sees pre-capture bank and pre-clear flags.
    always_comb begin
        rd_mux_c = '0;
        case (rd_addr)
            ADDR_W'(ADDR_IE):     rd_mux_c = DATA_W'(ie_q);
            ADDR_W'(ADDR_QE):     rd_mux_c = DATA_W'(qe_q);
            ADDR_W'(ADDR_IP):     rd_mux_c = DATA_W'(ip_q);
            ADDR_W'(ADDR_QP):     rd_mux_c = DATA_W'(qp_q);
            ADDR_W'(ADDR_IL):     rd_mux_c = DATA_W'(il_q);
            ADDR_W'(ADDR_QL):     rd_mux_c = DATA_W'(ql_q);
            ADDR_W'(ADDR_CARR):   rd_mux_c = DATA_W'(meas_q.carrier);
            ADDR_W'(ADDR_CODE):   rd_mux_c = DATA_W'(meas_q.code);
            ADDR_W'(ADDR_EPOCH):  rd_mux_c = DATA_W'(meas_q.epoch);
            ADDR_W'(ADDR_EPCHK):  rd_mux_c = DATA_W'(meas_q.epoch_check);
            ADDR_W'(ADDR_STATUS): rd_mux_c = DATA_W'(status_c);
            default:              rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            accum_int <= 1'b0;
        end else begin
            accum_int <= dump | (accum_new & ~status_rd_c);
        end
    end

endmodule

// File: tb/tb_channel_readout.sv
// Directed bench for channel_readout: expected read data is queued when a
// read is issued and checked when rd_valid returns.
module tb_channel_readout;

    logic               clk;
    logic               rstn;
    logic               dump;
    logic               tic_enable;
    logic signed [15:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
    logic [31:0]        carrier_val;
    logic [20:0]        code_val;
    logic [10:0]        epoch;
    logic [10:0]        epoch_check;
    logic               rd_en;
    logic [3:0]         rd_addr;
    logic [31:0]        rd_data;
    logic               rd_valid;
    logic               accum_int;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [31:0]        sb[$];

    channel_readout #(.ACC_W(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .dump        (dump),
        .tic_enable  (tic_enable),
        .i_early     (i_early),
        .q_early     (q_early),
        .i_prompt    (i_prompt),
        .q_prompt    (q_prompt),
        .i_late      (i_late),
        .q_late      (q_late),
        .carrier_val (carrier_val),
        .code_val    (code_val),
        .epoch       (epoch),
        .epoch_check (epoch_check),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .accum_int   (accum_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_dump();
        @(negedge clk);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
    endtask

    // Read with optional capture strobes in the same cycle; checks the
    // one-cycle valid window and that rd_data holds afterwards.
    task automatic do_read(input logic [3:0] a, input logic [31:0] exp,
                           input logic with_dump, input logic with_tic);
        logic [31:0] e;
        @(negedge clk);
        rd_en      = 1'b1;
        rd_addr    = a;
        dump       = with_dump;
        tic_enable = with_tic;
        sb.push_back(exp);
        @(negedge clk);
        rd_en      = 1'b0;
        dump       = 1'b0;
        tic_enable = 1'b0;
        chk($sformatf("rd_valid_a%0d", a), 32'(rd_valid), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("rd_data_a%0d", a), rd_data, e);
            @(negedge clk);
            chk($sformatf("rd_valid_drop_a%0d", a), 32'(rd_valid), 32'd0);
            chk($sformatf("rd_data_hold_a%0d", a), rd_data, e);
        end
    endtask

    initial begin
        rstn = 1'b0; dump = 1'b0; tic_enable = 1'b0; rd_en = 1'b0; rd_addr = '0;
        i_early = '0; q_early = '0; i_prompt = '0; q_prompt = '0; i_late = '0; q_late = '0;
        carrier_val = '0; code_val = '0; epoch = '0; epoch_check = '0;

        // 1: reset state
        repeat (3) @(negedge clk);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_accum_int", 32'(accum_int), 32'h0);
        rstn = 1'b1;
        do_read(4'd10, 32'h0, 1'b0, 1'b0);
        do_read(4'd0, 32'h0, 1'b0, 1'b0);

        // 2: sign-extended accumulation
        i_early = 16'hFFFE;
        pulse_dump();
        chk("accum_int_after_dump", 32'(accum_int), 32'h1);
        do_read(4'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        chk("accum_int_held", 32'(accum_int), 32'h1);
        do_read(4'd10, 32'h1, 1'b0, 1'b0);
        chk("accum_int_cleared", 32'(accum_int), 32'h0);

        // 3: overrun sets missed
        pulse_dump();
        q_late = 16'sd5;
        pulse_dump();
        do_read(4'd10, 32'h3, 1'b0, 1'b0);
        do_read(4'd5, 32'h5, 1'b0, 1'b0);
        do_read(4'd10, 32'h0, 1'b0, 1'b0);
        chk("accum_int_t3", 32'(accum_int), 32'h0);
        do_read(4'd15, 32'h0, 1'b0, 1'b0);

        // 4: status read coincident with dump
        do_read(4'd10, 32'h0, 1'b1, 1'b0);
        chk("accum_int_set_wins", 32'(accum_int), 32'h1);
        do_read(4'd10, 32'h1, 1'b0, 1'b0);
        i_early = 16'sd7;
        do_read(4'd0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        do_read(4'd0, 32'h7, 1'b0, 1'b0);
        do_read(4'd10, 32'h1, 1'b1, 1'b0);
        do_read(4'd10, 32'h3, 1'b0, 1'b0);

        // 5: measurement bank
        code_val = 21'h1FFFFF; epoch = 11'h7FF; carrier_val = 32'hDEAD_BEEF; epoch_check = 11'h123;
        @(negedge clk);
        tic_enable = 1'b1;
        @(negedge clk);
        tic_enable = 1'b0;
        chk("accum_int_tic_only", 32'(accum_int), 32'h0);
        do_read(4'd7, 32'h001F_FFFF, 1'b0, 1'b0);
        do_read(4'd8, 32'h0000_07FF, 1'b0, 1'b0);
        do_read(4'd6, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_read(4'd9, 32'h0000_0123, 1'b0, 1'b0);
        do_read(4'd10, 32'h4, 1'b0, 1'b0);

        // simultaneous dump and tic, then measurement overrun
        i_prompt = -16'sd3; epoch = 11'h001;
        @(negedge clk);
        dump = 1'b1; tic_enable = 1'b1;
        @(negedge clk);
        dump = 1'b0; tic_enable = 1'b0;
        do_read(4'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_read(4'd8, 32'h1, 1'b0, 1'b1);
        do_read(4'd10, 32'hD, 1'b0, 1'b0);

        // 6: reset during a read
        pulse_dump();
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 4'd0;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("pre_reset_rd_valid", 32'(rd_valid), 32'h1);
        rstn = 1'b0;
        #1;
        chk("async_rd_valid", 32'(rd_valid), 32'h0);
        chk("async_accum_int", 32'(accum_int), 32'h0);
        chk("async_rd_data", rd_data, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        do_read(4'd10, 32'h0, 1'b0, 1'b0);
        do_read(4'd0, 32'h0, 1'b0, 1'b0);
        do_read(4'd6, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
